// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and geometry helpers for the dcache_wb write-back data cache.
//   state_t        : controller states (RUN, WRITE_BACK, ALLOCATE)
//   ADDR_W/DATA_W  : byte address and data word widths (32)
//   OFF_W          : byte-offset bits inside a 32-bit word
//   word_w/index_w/tag_w : address field widths derived from the cache
//                    parameters LINES and WORDS_PER_LINE
//   safe_w         : widens a zero-width field to 1 bit for storage
// DEF_* localparams give the field widths of the default geometry.
// -----------------------------------------------------------------------------
package dcache_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OFF_W  = 2;

  function automatic int word_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words_per_line);
    return ADDR_W - OFF_W - $clog2(words_per_line) - $clog2(lines);
  endfunction

  // A single-word line has no word-select field; keep 1 bit for registers.
  function automatic int safe_w(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_LINES          = 256;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_WORD_W  = word_w(DEF_WORDS_PER_LINE);
  localparam int DEF_INDEX_W = index_w(DEF_LINES);
  localparam int DEF_TAG_W   = tag_w(DEF_LINES, DEF_WORDS_PER_LINE);

endpackage

// File: rtl/dcache_wb_tagram.sv
// -----------------------------------------------------------------------------
// dcache_wb_tagram
// Valid, dirty and tag storage of the direct-mapped cache.
//   clk, rst          : clock, asynchronous active-low reset (clears valid/dirty)
//   index, tag        : decoded fields of the current request address
//   set_dirty         : a write hit lands in the line at index
//   clear_dirty       : the line at index has been written back
//   fill              : refill done; mark line valid and store tag
//   hit               : line valid and its tag matches
//   dirty             : line valid and modified (victim needs write-back)
//   victim_tag        : tag currently stored at index
// The tag array is never reset; valid gates every use of it.
// -----------------------------------------------------------------------------
module dcache_wb_tagram
  import dcache_pkg::*;
#(
  parameter int LINES = 256,
  parameter int IDX_W = 8,
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  input  logic [TAG_W-1:0] tag,
  input  logic             set_dirty,
  input  logic             clear_dirty,
  input  logic             fill,
  output logic             hit,
  output logic             dirty,
  output logic [TAG_W-1:0] victim_tag
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill) valid_q[index] <= 1'b1;
      if (set_dirty) begin
        dirty_q[index] <= 1'b1;
      end else if (clear_dirty) begin
        dirty_q[index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) tag_q[index] <= tag;
  end

  assign victim_tag = tag_q[index];
  assign hit        = valid_q[index] && (tag_q[index] == tag);
  assign dirty      = valid_q[index] && dirty_q[index];

endmodule

// File: rtl/dcache_wb.sv
// -----------------------------------------------------------------------------
// dcache_wb
// Direct-mapped, write-back, write-allocate data cache with a single-beat
// memory port. Hits complete combinationally in RUN; a miss writes back a
// dirty victim (WRITE_BACK), refills the line (ALLOCATE) and returns to RUN,
// where the still-held request then hits.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   addr                     : word-aligned byte address (addr[1:0] ignored)
//   rreq, wreq               : read / write request, held until rvalid/wvalid
//   wdata, byte_enable       : write data and byte-lane mask
//   rdata, rvalid, wvalid    : read data/done, write accepted
//   mem_req, mem_we          : memory beat request, beat is a write
//   mem_addr, mem_wdata      : beat address, write-back data
//   mem_ack, mem_rdata       : beat complete, refill data
//   hit_count, miss_count    : only with DCACHE_WB_STATS_EN defined
// Optional feature macro: DCACHE_WB_STATS_EN (access statistics counters).
// -----------------------------------------------------------------------------
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int LINES          = 256,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rreq,
  input  logic              wreq,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        byte_enable,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_WB_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int WORD_W  = word_w(WORDS_PER_LINE);
  localparam int WORD_SW = safe_w(WORD_W);
  localparam int IDX_W   = index_w(LINES);
  localparam int TAG_W   = tag_w(LINES, WORDS_PER_LINE);
  localparam int LINE_SH = OFF_W + WORD_W;
  localparam int TAG_SH  = LINE_SH + IDX_W;

  logic [WORD_SW-1:0] word;
  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;

  // Shift-and-mask decode keeps a one-word line (no word field) legal.
  assign word  = WORD_SW'((addr >> OFF_W) & ADDR_W'(WORDS_PER_LINE - 1));
  assign index = IDX_W'(addr >> LINE_SH);
  assign tag   = TAG_W'(addr >> TAG_SH);

  state_t             state_q, state_d;
  logic [WORD_SW-1:0] beat_q, beat_d;
  logic               last_beat;
  logic               hit, victim_dirty;
  logic [TAG_W-1:0]   victim_tag;
  logic               set_dirty, clear_dirty, fill, refill_we, miss;
  logic [ADDR_W-1:0]  line_base_wb, line_base_alloc;

  logic [DATA_W-1:0]  data_q [LINES][WORDS_PER_LINE];

  assign last_beat = (beat_q == WORD_SW'(WORDS_PER_LINE - 1));

  // Beat address = {tag, index, beat, 2'b00}; only the tag differs between
  // writing back the victim and refilling the requested line.
  assign line_base_wb    = (ADDR_W'(victim_tag) << TAG_SH) | (ADDR_W'(index) << LINE_SH)
                         | (ADDR_W'(beat_q) << OFF_W);
  assign line_base_alloc = (ADDR_W'(tag) << TAG_SH) | (ADDR_W'(index) << LINE_SH)
                         | (ADDR_W'(beat_q) << OFF_W);

  dcache_wb_tagram #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tagram (
    .clk         (clk),
    .rst         (rst),
    .index       (index),
    .tag         (tag),
    .set_dirty   (set_dirty),
    .clear_dirty (clear_dirty),
    .fill        (fill),
    .hit         (hit),
    .dirty       (victim_dirty),
    .victim_tag  (victim_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    rdata       = '0;
    rvalid      = 1'b0;
    wvalid      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    set_dirty   = 1'b0;
    clear_dirty = 1'b0;
    fill        = 1'b0;
    refill_we   = 1'b0;
    miss        = 1'b0;
    case (state_q)
      RUN: begin
        // A simultaneous read and write is served as the write alone.
        if (wreq) begin
          if (hit) begin
            wvalid    = 1'b1;
            set_dirty = 1'b1;
          end else begin
            miss = 1'b1;
          end
        end else if (rreq) begin
          if (hit) begin
            rvalid = 1'b1;
            rdata  = data_q[index][word];
          end else begin
            miss = 1'b1;
          end
        end
        if (miss) state_d = victim_dirty ? WRITE_BACK : ALLOCATE;
      end
      WRITE_BACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_base_wb;
        mem_wdata = data_q[index][beat_q];
        if (mem_ack) begin
          if (last_beat) begin
            state_d     = ALLOCATE;
            beat_d      = '0;
            clear_dirty = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = line_base_alloc;
        if (mem_ack) begin
          refill_we = 1'b1;
          if (last_beat) begin
            state_d = RUN;
            beat_d  = '0;
            fill    = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Data array is not reset; valid bits decide whether its contents count.
  always_ff @(posedge clk) begin
    if (set_dirty) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enable[b]) data_q[index][word][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (refill_we) data_q[index][beat_q] <= mem_rdata;
  end

`ifdef DCACHE_WB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rvalid || wvalid) hit_count <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// -----------------------------------------------------------------------------
// tb_dcache_wb
// Self-checking bench for dcache_wb (LINES=4, WORDS_PER_LINE=4). A memory
// responder acks each beat two cycles after it is requested. The reference
// keeps the architectural memory image and which line each index holds.
// -----------------------------------------------------------------------------
module tb_dcache_wb;

  localparam int LINES = 4;
  localparam int WPL   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        rreq = 1'b0;
  logic        wreq = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] rdata;
  logic        rvalid, wvalid, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef DCACHE_WB_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_wb #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .rreq        (rreq),
    .wreq        (wreq),
    .wdata       (wdata),
    .byte_enable (byte_enable),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .wvalid      (wvalid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef DCACHE_WB_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  logic [31:0] mem    [bit [31:0]];  // physical memory behind the cache
  logic [31:0] golden [bit [31:0]];  // what a read must return
  beat_t       beat_log[$];
  beat_t       exp_beats[$];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] last_rdata;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'hC0DE0000 | (a & 32'h0000FFFF);
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] gold_get(input logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack two cycles into each beat, check the beat is held.
  initial begin
    int          cnt;
    logic [31:0] hold_a, hold_d;
    logic        hold_we;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst || mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt == 0) begin
          hold_a = mem_addr;
          hold_d = mem_wdata;
          hold_we = mem_we;
        end else begin
          chk("beat_addr_stable", mem_addr, hold_a);
          chk("beat_we_stable", 32'(mem_we), 32'(hold_we));
          if (mem_we) chk("beat_wdata_stable", mem_wdata, hold_d);
        end
        cnt++;
        if (cnt == 2) begin
          beat_log.push_back('{we: mem_we, a: mem_addr, d: mem_wdata});
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            mem_rdata = '0;
          end else begin
            mem_rdata = mem_get(mem_addr);
          end
          mem_ack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Per-cycle output checks against the reference image.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
      end else begin
        if (rvalid) begin
          chk("rvalid_only_read", 32'({rreq, wreq}), 32'b10);
          chk("mon_rdata", rdata, gold_get(addr & 32'hFFFFFFFC));
        end else begin
          chk("rdata_zero_idle", rdata, 32'd0);
        end
        if (wvalid) chk("wvalid_has_wreq", 32'(wreq), 32'd1);
        if (mem_req) chk("no_valid_during_burst", 32'({rvalid, wvalid}), 32'd0);
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] la;
    int          idx;
    int unsigned tg;
    bit          exp_hit, done;
    int          n;
    logic [31:0] old;
    la  = a & 32'hFFFFFFFC;
    idx = int'((la >> 4) % LINES);
    tg  = la >> 6;
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_beats.delete();
    if (!exp_hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int k = 0; k < WPL; k++) begin
          logic [31:0] va;
          va = 32'((m_tag[idx] << 6) | (idx << 4) | (k << 2));
          exp_beats.push_back('{we: 1'b1, a: va, d: gold_get(va)});
        end
      end
      for (int k = 0; k < WPL; k++)
        exp_beats.push_back('{we: 1'b0, a: 32'((tg << 6) | (idx << 4) | (k << 2)), d: 32'd0});
    end
    @(negedge clk);
    beat_log.delete();
    addr = a; rreq = rd; wreq = wr; wdata = wd; byte_enable = be;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      #1;
      if (wr ? wvalid : rvalid) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    chk("access_completes", 32'(done), 32'd1);
    if (done) begin
      chk("hit_zero_latency", 32'(n == 0), 32'(exp_hit));
      if (wr) begin
        chk("rvalid_low_on_write", 32'(rvalid), 32'd0);
        old = gold_get(la);
        for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
        golden[la] = old;
      end else begin
        last_rdata = rdata;
        chk("read_data", rdata, gold_get(la));
      end
      chk("beat_count", 32'(beat_log.size()), 32'(exp_beats.size()));
      for (int i = 0; i < beat_log.size() && i < exp_beats.size(); i++) begin
        chk("beat_we", 32'(beat_log[i].we), 32'(exp_beats[i].we));
        chk("beat_addr", beat_log[i].a, exp_beats[i].a);
        if (exp_beats[i].we) chk("beat_wdata", beat_log[i].d, exp_beats[i].d);
      end
      if (!exp_hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_dirty[idx] = 1'b0;
      end
      if (wr) m_dirty[idx] = 1'b1;
    end
    @(negedge clk);
    rreq = 1'b0;
    wreq = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b1;

    // Cold read miss: refill of line 0x100..0x10C, then hit.
    access(1'b1, 1'b0, 32'h100, 32'd0, 4'h0);
    chk("r033_nbeats", 32'(beat_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < beat_log.size()) chk("r033_refill_addr", beat_log[k].a, 32'h100 + 32'(4 * k));
    end
    chk("r033_rdata", last_rdata, 32'hC0DE0100);

    // Partial write hit, then read back the merged word.
    access(1'b0, 1'b1, 32'h104, 32'hAABBCCDD, 4'b0011);
    access(1'b1, 1'b0, 32'h104, 32'd0, 4'h0);
    chk("r034_merged", last_rdata, 32'hC0DECCDD);

    // Conflict miss on a dirty line: write-back then refill.
    access(1'b1, 1'b0, 32'h140, 32'd0, 4'h0);
    chk("r035_nbeats", 32'(beat_log.size()), 32'd8);
    if (beat_log.size() == 8) begin
      chk("r035_wb0_we", 32'(beat_log[0].we), 32'd1);
      chk("r035_wb1_addr", beat_log[1].a, 32'h104);
      chk("r035_wb1_data", beat_log[1].d, 32'hC0DECCDD);
      chk("r035_refill_addr", beat_log[4].a, 32'h140);
      chk("r035_refill_we", 32'(beat_log[4].we), 32'd0);
    end

    // Read and write together on a hit: only the write happens.
    access(1'b1, 1'b1, 32'h144, 32'h11223344, 4'hF);
    access(1'b1, 1'b0, 32'h144, 32'd0, 4'h0);
    chk("r037_write_only", last_rdata, 32'h11223344);

    // Reset during the second write-back beat of the dirty 0x140 line.
    @(negedge clk);
    beat_log.delete();
    addr = 32'h100;
    rreq = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #3;
      if (beat_log.size() == 1 && mem_req && !mem_ack) found = 1'b1;
    end
    chk("r036_reached_beat2", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("r036_mem_req_now", 32'(mem_req), 32'd0);
    chk("r036_rvalid_now", 32'(rvalid), 32'd0);
    rreq = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    golden = mem;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    access(1'b1, 1'b0, 32'h100, 32'd0, 4'h0);
    chk("r036_no_wb_nbeats", 32'(beat_log.size()), 32'd4);
    if (beat_log.size() > 0) chk("r036_first_is_read", 32'(beat_log[0].we), 32'd0);
    access(1'b1, 1'b0, 32'h144, 32'd0, 4'h0);
    chk("r036_lost_dirty", last_rdata, 32'hC0DE0144);

    // Randomised traffic over 16 tags x 4 lines x 4 words.
    for (int t = 0; t < 250; t++) begin
      int          op;
      logic [31:0] ra;
      op = int'($urandom_range(0, 2));
      ra = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      access(op != 1, op != 0, ra, $urandom, 4'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
